// File: rtl/light_sequencer.sv
// Control front-end for the lights selector: button synchroniser/debouncer plus WHITE/MANUAL/AUTO mode FSM.
// Optional long-press white toggle is compiled in with `define LIGHT_SEQ_LONG_PRESS_EN.
module light_sequencer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int AUTO_PERIOD     = 1000,
  parameter int LONG_CYCLES     = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_raw,
  input  logic       white_req,
  input  logic       auto_en,
  output logic       advance,
  output logic       sel,
  output logic       enable,
  output logic [2:0] colour_idx,
  output logic [1:0] state
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int AP_W = $clog2(AUTO_PERIOD);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [AP_W-1:0] AP_LAST = AP_W'(AUTO_PERIOD - 1);

  localparam logic [1:0] ST_WHITE   = 2'b00;
  localparam logic [1:0] ST_MANUAL  = 2'b01;
  localparam logic [1:0] ST_AUTO    = 2'b10;
  localparam logic [1:0] ST_ILLEGAL = 2'b11;

  function automatic logic [2:0] next_colour(input logic [2:0] c);
    next_colour = (c >= 3'd6 || c == 3'd0) ? 3'd1 : c + 3'd1;
  endfunction

  logic            sync1_q, sync1_d, sync2_q, sync2_d;
  logic [1:0]      fill_q, fill_d;
  logic            arm_q, arm_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            btn_db_q, btn_db_d, btn_dly_q, btn_dly_d;
  logic            press;

  logic [1:0]      state_q, state_d;
  logic [AP_W-1:0] auto_cnt_q, auto_cnt_d;
  logic            advance_q, advance_d;
  logic            sel_q, sel_d, enable_q, enable_d;
  logic [2:0]      colour_q, colour_d;
  logic            wr_eff, lp_white;

  // Input path: 2-flop synchroniser, then a mismatch-run debouncer.
  // arm_q blocks a button that was already held through reset until it has been seen released.
  always_comb begin
    sync1_d   = btn_raw;
    sync2_d   = sync1_q;
    fill_d    = {fill_q[0], 1'b1};
    arm_d     = arm_q | (fill_q[1] & ~sync2_q);
    btn_dly_d = btn_db_q;
    btn_db_d  = btn_db_q;
    db_cnt_d  = '0;
    if (sync2_q != btn_db_q) begin
      if (db_cnt_q == DB_LAST) btn_db_d = sync2_q;
      else                     db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      fill_q    <= 2'b00;
      arm_q     <= 1'b0;
      db_cnt_q  <= '0;
      btn_db_q  <= 1'b0;
      btn_dly_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      fill_q    <= fill_d;
      arm_q     <= arm_d;
      db_cnt_q  <= db_cnt_d;
      btn_db_q  <= btn_db_d;
      btn_dly_q <= btn_dly_d;
    end
  end

  assign press = btn_db_q & ~btn_dly_q & arm_q;

`ifdef LIGHT_SEQ_LONG_PRESS_EN
  localparam int LP_W = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
  localparam logic [LP_W-1:0] LP_LAST = LP_W'(LONG_CYCLES - 1);

  logic [LP_W-1:0] lp_cnt_q, lp_cnt_d;
  logic            lp_done_q, lp_done_d, lp_white_q, lp_white_d;

  // lp_done_q limits the toggle to once per continuous hold.
  always_comb begin
    lp_cnt_d   = lp_cnt_q;
    lp_done_d  = lp_done_q;
    lp_white_d = lp_white_q;
    if (!btn_db_q) begin
      lp_cnt_d  = '0;
      lp_done_d = 1'b0;
    end else if (!lp_done_q) begin
      if (lp_cnt_q == LP_LAST) begin
        lp_white_d = ~lp_white_q;
        lp_done_d  = 1'b1;
      end else begin
        lp_cnt_d = lp_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lp_cnt_q   <= '0;
      lp_done_q  <= 1'b0;
      lp_white_q <= 1'b0;
    end else begin
      lp_cnt_q   <= lp_cnt_d;
      lp_done_q  <= lp_done_d;
      lp_white_q <= lp_white_d;
    end
  end

  assign lp_white = lp_white_q;
`else
  // Long press compiled out; the parameter stays so both builds share one interface.
  assign lp_white = (LONG_CYCLES < 0);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_WHITE;
    else      state_q <= state_d;
  end

  always_comb begin
    wr_eff = white_req | lp_white;
    if (state_q == ST_ILLEGAL || wr_eff) state_d = ST_WHITE;
    else if (auto_en)                    state_d = ST_AUTO;
    else                                 state_d = ST_MANUAL;
  end

  // Outputs are decided from the next state so they register in the same edge as state_q.
  always_comb begin
    logic active, terminal, leaving;
    active     = (state_q == ST_MANUAL) || (state_q == ST_AUTO);
    terminal   = (state_q == ST_AUTO) && (auto_cnt_q == AP_LAST);
    leaving    = (state_q != ST_AUTO) || (state_d != ST_AUTO);
    advance_d  = active && (state_d != ST_WHITE) && !advance_q && (press || terminal);
    sel_d      = (state_d != ST_WHITE);
    enable_d   = (state_d != ST_WHITE);
    auto_cnt_d = (leaving || press || terminal) ? '0 : auto_cnt_q + 1'b1;
    colour_d   = advance_q ? next_colour(colour_q) : colour_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      auto_cnt_q <= '0;
      advance_q  <= 1'b0;
      sel_q      <= 1'b0;
      enable_q   <= 1'b0;
      colour_q   <= 3'd1;
    end else begin
      auto_cnt_q <= auto_cnt_d;
      advance_q  <= advance_d;
      sel_q      <= sel_d;
      enable_q   <= enable_d;
      colour_q   <= colour_d;
    end
  end

  assign advance    = advance_q;
  assign sel        = sel_q;
  assign enable     = enable_q;
  assign colour_idx = colour_q;
  assign state      = state_q;

endmodule
